// File: rtl/rx_rs_pkg.sv
// Shared definitions for the receive RS link-fault monitor: fault codes,
// FSM encoding, ordered-set constants and the per-column classifier.
package rx_rs_pkg;

  typedef enum logic [1:0] {
    LF_OK     = 2'b00,
    LF_LOCAL  = 2'b01,
    LF_REMOTE = 2'b10
  } lf_t;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_COUNT = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  localparam logic [7:0]  SEQ_CHAR   = 8'h9C;
  localparam logic [23:0] SEQ_LOCAL  = 24'h000001;
  localparam logic [23:0] SEQ_REMOTE = 24'h000002;
  // A sequence ordered set carries control only on lane0 (the MSB byte).
  localparam logic [3:0]  SEQ_CTRL   = 4'b1000;

  function automatic lf_t col_classify(input logic [3:0] ctrl, input logic [31:0] data);
    lf_t t;
    t = LF_OK;
    if (ctrl == SEQ_CTRL && data[31:24] == SEQ_CHAR) begin
      if (data[23:0] == SEQ_LOCAL)       t = LF_LOCAL;
      else if (data[23:0] == SEQ_REMOTE) t = LF_REMOTE;
    end
    return t;
  endfunction

endpackage

// File: rtl/rx_rs_col_step.sv
// Combinational next-state of the fault FSM for one 32-bit XGMII column.
// Two copies are chained so column0 is applied before column1.
module rx_rs_col_step
  import rx_rs_pkg::*;
#(
  parameter int SEQ_THRESHOLD = 4,
  parameter int COL_WINDOW    = 128,
  parameter int SEQ_W         = $clog2(SEQ_THRESHOLD) + 1,
  parameter int COL_W         = $clog2(COL_WINDOW) + 1
) (
  input  logic [3:0]       i_ctrl,
  input  logic [31:0]      i_data,
  input  logic [1:0]       i_state,
  input  logic [1:0]       i_last_type,
  input  logic [SEQ_W-1:0] i_seq_cnt,
  input  logic [COL_W-1:0] i_col_cnt,
  input  logic [1:0]       i_link_fault,
  output logic [1:0]       o_col_type,
  output logic [1:0]       o_state,
  output logic [1:0]       o_last_type,
  output logic [SEQ_W-1:0] o_seq_cnt,
  output logic [COL_W-1:0] o_col_cnt,
  output logic [1:0]       o_link_fault
);

  localparam logic [SEQ_W-1:0] SEQ_LIMIT = SEQ_W'(SEQ_THRESHOLD);
  localparam logic [COL_W-1:0] COL_LIMIT = COL_W'(COL_WINDOW);
  localparam logic [COL_W-1:0] COL_MAX   = {COL_W{1'b1}};

  lf_t              w_type;
  logic [SEQ_W-1:0] w_seq_inc;
  logic [COL_W-1:0] w_col_inc;

  assign w_type     = col_classify(i_ctrl, i_data);
  assign o_col_type = w_type;
  assign w_seq_inc  = i_seq_cnt + 1'b1;
  assign w_col_inc  = (i_col_cnt == COL_MAX) ? i_col_cnt : i_col_cnt + 1'b1;

  always_comb begin
    o_state      = i_state;
    o_last_type  = i_last_type;
    o_seq_cnt    = i_seq_cnt;
    o_col_cnt    = i_col_cnt;
    o_link_fault = i_link_fault;
    case (i_state)
      ST_INIT: begin
        o_last_type  = LF_OK;
        o_seq_cnt    = '0;
        o_col_cnt    = '0;
        o_link_fault = LF_OK;
        if (w_type != LF_OK) begin
          o_state     = ST_COUNT;
          o_last_type = w_type;
          o_seq_cnt   = SEQ_W'(1);
        end
      end
      ST_COUNT, ST_FAULT: begin
        if (w_type == LF_OK) begin
          o_col_cnt = w_col_inc;
          // A full fault-free window drops back to INIT from either state.
          if (w_col_inc >= COL_LIMIT) begin
            o_state      = ST_INIT;
            o_last_type  = LF_OK;
            o_seq_cnt    = '0;
            o_col_cnt    = '0;
            o_link_fault = LF_OK;
          end
        end else if (w_type == i_last_type) begin
          o_col_cnt = '0;
          if (i_state == ST_COUNT) begin
            o_seq_cnt = w_seq_inc;
            if (w_seq_inc == SEQ_LIMIT) begin
              o_state      = ST_FAULT;
              o_link_fault = i_last_type;
            end
          end
        end else begin
          // Type change restarts the count; any confirmed fault stays visible.
          o_state     = ST_COUNT;
          o_last_type = w_type;
          o_seq_cnt   = SEQ_W'(1);
          o_col_cnt   = '0;
        end
      end
      default: begin
        o_state      = ST_INIT;
        o_last_type  = LF_OK;
        o_seq_cnt    = '0;
        o_col_cnt    = '0;
        o_link_fault = LF_OK;
      end
    endcase
  end

endmodule

// File: rtl/rx_rs_fault_detect.sv
// XGMII receive link-fault monitor: two chained column steps per clock,
// with the FSM state, counters and output strobes registered here.
module rx_rs_fault_detect
  import rx_rs_pkg::*;
#(
  parameter int SEQ_THRESHOLD = 4,
  parameter int COL_WINDOW    = 128
) (
  input  logic        rxclk_in,
  input  logic        reset_in,
  input  logic [63:0] rxd64,
  input  logic [7:0]  rxc8,
  input  logic        fault_detect_en,
  output logic [1:0]  link_fault,
  output logic        seq_local_det,
  output logic        seq_remote_det,
  output logic [1:0]  o_dbg_state
);

  localparam int SEQ_W = $clog2(SEQ_THRESHOLD) + 1;
  localparam int COL_W = $clog2(COL_WINDOW) + 1;

  state_t           r_state;
  logic [1:0]       r_last_type;
  logic [SEQ_W-1:0] r_seq_cnt;
  logic [COL_W-1:0] r_col_cnt;
  logic [1:0]       r_link_fault;
  logic             r_local_det;
  logic             r_remote_det;

  logic [1:0]       w0_type, w1_type;
  logic [1:0]       w0_state, w1_state;
  logic [1:0]       w0_last_type, w1_last_type;
  logic [SEQ_W-1:0] w0_seq_cnt, w1_seq_cnt;
  logic [COL_W-1:0] w0_col_cnt, w1_col_cnt;
  logic [1:0]       w0_link_fault, w1_link_fault;

  rx_rs_col_step #(
    .SEQ_THRESHOLD(SEQ_THRESHOLD), .COL_WINDOW(COL_WINDOW), .SEQ_W(SEQ_W), .COL_W(COL_W)
  ) u_col0 (
    .i_ctrl(rxc8[7:4]), .i_data(rxd64[63:32]),
    .i_state(r_state), .i_last_type(r_last_type), .i_seq_cnt(r_seq_cnt),
    .i_col_cnt(r_col_cnt), .i_link_fault(r_link_fault),
    .o_col_type(w0_type), .o_state(w0_state), .o_last_type(w0_last_type),
    .o_seq_cnt(w0_seq_cnt), .o_col_cnt(w0_col_cnt), .o_link_fault(w0_link_fault)
  );

  rx_rs_col_step #(
    .SEQ_THRESHOLD(SEQ_THRESHOLD), .COL_WINDOW(COL_WINDOW), .SEQ_W(SEQ_W), .COL_W(COL_W)
  ) u_col1 (
    .i_ctrl(rxc8[3:0]), .i_data(rxd64[31:0]),
    .i_state(w0_state), .i_last_type(w0_last_type), .i_seq_cnt(w0_seq_cnt),
    .i_col_cnt(w0_col_cnt), .i_link_fault(w0_link_fault),
    .o_col_type(w1_type), .o_state(w1_state), .o_last_type(w1_last_type),
    .o_seq_cnt(w1_seq_cnt), .o_col_cnt(w1_col_cnt), .o_link_fault(w1_link_fault)
  );

  always_ff @(posedge rxclk_in or posedge reset_in) begin
    if (reset_in) begin
      r_state      <= ST_INIT;
      r_last_type  <= LF_OK;
      r_seq_cnt    <= '0;
      r_col_cnt    <= '0;
      r_link_fault <= LF_OK;
      r_local_det  <= 1'b0;
      r_remote_det <= 1'b0;
    end else begin
      // Detection strobes run even while the FSM is disabled.
      r_local_det  <= (w0_type == LF_LOCAL)  || (w1_type == LF_LOCAL);
      r_remote_det <= (w0_type == LF_REMOTE) || (w1_type == LF_REMOTE);
      if (!fault_detect_en) begin
        r_state      <= ST_INIT;
        r_last_type  <= LF_OK;
        r_seq_cnt    <= '0;
        r_col_cnt    <= '0;
        r_link_fault <= LF_OK;
      end else begin
        r_state      <= state_t'(w1_state);
        r_last_type  <= w1_last_type;
        r_seq_cnt    <= w1_seq_cnt;
        r_col_cnt    <= w1_col_cnt;
        r_link_fault <= w1_link_fault;
      end
    end
  end

  assign link_fault     = r_link_fault;
  assign seq_local_det  = r_local_det;
  assign seq_remote_det = r_remote_det;
  assign o_dbg_state    = r_state;

endmodule
